// File: rtl/app_packet_sender_pkg.sv
// Shared constants, FSM encoding and round-robin helper for the packet sender.
package app_packet_sender_pkg;

    localparam logic [7:0] START_MARKER  = 8'hA5;
    localparam int         DATA_BYTES    = 2;
    localparam logic [7:0] FILL_BYTE     = 8'hFF;
    localparam logic [9:0] FETCH_TIMEOUT = 10'd1023;

    // Byte positions within a packet: marker, header, data..., checksum.
    localparam int         PKT_BYTES  = DATA_BYTES + 3;
    localparam logic [2:0] POS_HEADER = 3'd1;
    localparam logic [2:0] POS_CHK    = 3'(PKT_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_START_PKT = 3'd2,
        ST_FETCH     = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_TX   = 3'd5,
        ST_GAP       = 3'd6
    } state_e;

    // First set bit strictly after 'last', wrapping; 'last' itself is the final candidate.
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] last);
        logic [2:0] cand;
        rr_pick = last;
        for (int k = 8; k >= 1; k--) begin
            cand = last + 3'(k);
            if (mask[cand]) begin
                rr_pick = cand;
            end
        end
    endfunction

endpackage

// File: rtl/app_packet_sender_timer_10bit.sv
// Saturating 10-bit cycle counter, shared by the inter-byte gap and the fetch timeout.
module app_packet_sender_timer_10bit (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    output logic [9:0] count_o
);

    logic [9:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 10'd0;
        end else if (count_q != 10'h3FF) begin
            count_d = count_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 10'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/app_packet_sender.sv
// Round-robin stream packetiser: frames two source bytes per packet with marker,
// header and XOR checksum, and paces them byte-by-byte into a UART transmitter.
module app_packet_sender
    import app_packet_sender_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       ds_sending_flag,
    input  logic [7:0] stream_select,
    input  logic [9:0] uart_byte_spacing,
    input  logic [7:0] stream_data,
    input  logic       stream_valid,
    output logic [2:0] stream_index,
    output logic       stream_ready,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    output logic       busy,
    output logic [7:0] packet_count,
    output logic       fetch_error
);

    state_e     state_q, state_d;
    logic [2:0] byte_pos_q, byte_pos_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [7:0] chk_q, chk_d;
    logic [2:0] index_q, index_d;
    logic [2:0] last_q, last_d;
    logic [7:0] count_q, count_d;
    logic       err_q, err_d;

    logic [9:0] timer_count;
    logic       timer_clear;
    logic       gap_done;
    logic       fetch_expired;
    logic [2:0] next_pos;

    // The timer restarts on every state change, so each Gap/Fetch visit counts from 0.
    assign timer_clear   = (state_d != state_q);
    assign gap_done      = ({1'b0, timer_count} + 11'd1) >= {1'b0, uart_byte_spacing};
    assign fetch_expired = (timer_count == FETCH_TIMEOUT - 10'd1);
    assign next_pos      = byte_pos_q + 3'd1;

    app_packet_sender_timer_10bit u_timer (
        .clk_i   (clock),
        .rst_ni  (resetn),
        .clear_i (timer_clear),
        .count_o (timer_count)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            byte_pos_q <= 3'd0;
            tx_byte_q  <= 8'h00;
            chk_q      <= 8'h00;
            index_q    <= 3'd0;
            last_q     <= 3'd7;
            count_q    <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            byte_pos_q <= byte_pos_d;
            tx_byte_q  <= tx_byte_d;
            chk_q      <= chk_d;
            index_q    <= index_d;
            last_q     <= last_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_pos_d = byte_pos_q;
        tx_byte_d  = tx_byte_q;
        chk_d      = chk_q;
        index_d    = index_q;
        last_d     = last_q;
        count_d    = count_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ds_sending_flag && (stream_select != 8'h00)) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (stream_select == 8'h00) begin
                    state_d = ST_IDLE;
                end else begin
                    index_d = rr_pick(stream_select, last_q);
                    last_d  = index_d;
                    state_d = ST_START_PKT;
                end
            end
            ST_START_PKT: begin
                tx_byte_d  = START_MARKER;
                byte_pos_d = 3'd0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    if (byte_pos_q == POS_CHK) begin
                        count_d = count_q + 8'd1;
                        state_d = ds_sending_flag ? ST_SCAN : ST_IDLE;
                    end else begin
                        byte_pos_d = next_pos;
                        if (next_pos == POS_HEADER) begin
                            tx_byte_d = {5'b0, index_q};
                            chk_d     = {5'b0, index_q};
                            state_d   = ST_SEND;
                        end else if (next_pos == POS_CHK) begin
                            tx_byte_d = chk_q;
                            state_d   = ST_SEND;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
            end
            ST_FETCH: begin
                // A byte arriving on the final allowed cycle still wins over the filler.
                if (stream_valid) begin
                    tx_byte_d = stream_data;
                    chk_d     = chk_q ^ stream_data;
                    state_d   = ST_SEND;
                end else if (fetch_expired) begin
                    tx_byte_d = FILL_BYTE;
                    chk_d     = chk_q ^ FILL_BYTE;
                    err_d     = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_start     = 1'b0;
        stream_ready = 1'b0;
        busy         = 1'b1;
        case (state_q)
            ST_IDLE, ST_SCAN: busy         = 1'b0;
            ST_SEND:          tx_start     = 1'b1;
            ST_FETCH:         stream_ready = 1'b1;
            default:          busy         = 1'b1;
        endcase
    end

    assign tx_byte      = tx_byte_q;
    assign stream_index = index_q;
    assign packet_count = count_q;
    assign fetch_error  = err_q;

endmodule
